// File: rtl/text_console_writer.sv
// Terminal-style writer for the character generator's CPU-side text RAM port.
// Consumes a byte stream, writes {attr,char} at a hardware cursor, handles
// CR/LF/BS/FF, and does clear and scroll through the same single RAM port.
module text_console_writer #(
  parameter int unsigned N_COL          = 240,
  parameter int unsigned N_ROW          = 67,
  parameter int unsigned TEXTADDR_WIDTH = $clog2(N_COL * N_ROW),
  parameter bit          SYNC_VBLANK    = 1'b0
) (
  input  logic                       cpu_clk,
  input  logic                       rst_n,
  input  logic                       char_valid,
  input  logic [7:0]                 char_data,
  output logic                       char_ready,
  input  logic [7:0]                 attr,
  input  logic [7:0]                 clr_attr,
  input  logic                       vBlank,
  output logic [15:0]                cpu_addr,
  output logic                       cpu_we,
  output logic                       cpu_oe,
  output logic [15:0]                cpu_dataOut,
  input  logic [15:0]                cpu_dataIn,
  output logic [$clog2(N_COL)-1:0]   cursor_col,
  output logic [$clog2(N_ROW)-1:0]   cursor_row,
  output logic                       busy
);

  localparam int unsigned COL_W        = $clog2(N_COL);
  localparam int unsigned ROW_W        = $clog2(N_ROW);
  localparam int unsigned AW           = TEXTADDR_WIDTH;
  localparam int unsigned CELLS        = N_COL * N_ROW;
  localparam int unsigned SCROLL_CELLS = N_COL * (N_ROW - 1);

  localparam logic [AW-1:0]    LAST_CELL   = AW'(CELLS - 1);
  localparam logic [AW-1:0]    LAST_SCROLL = AW'(SCROLL_CELLS - 1);
  localparam logic [AW-1:0]    FILL_BASE   = AW'(SCROLL_CELLS);
  localparam logic [AW-1:0]    ROW1_BASE   = AW'(N_COL);
  localparam logic [COL_W-1:0] LAST_COL    = COL_W'(N_COL - 1);
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(N_ROW - 1);

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_DEL   = 8'h7F;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SCR_RD,
    SCR_WAIT,
    SCR_WR,
    FILL,
    CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic              char_ready_q, char_ready_d;
  logic              we_q, we_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              vb_meta_q, vb_sync_q;

  logic              go_c;
  logic              accept_c;
  logic              is_print_c;
  logic              adv_row_c;

  // Linear cell address of a cursor position.
  function automatic logic [AW-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                               input logic [COL_W-1:0] c);
    return AW'(32'(r) * N_COL + 32'(c));
  endfunction

  // RAM strobes may only be issued while the synchronised vBlank is high,
  // unless gating is disabled, in which case the port is always available.
  assign go_c       = vb_sync_q | ~SYNC_VBLANK;
  assign accept_c   = char_ready_q & char_valid;
  assign is_print_c = (char_data >= CH_SPACE) && (char_data != CH_DEL);

  // Next-state, next-output and cursor logic.
  always_comb begin
    state_d      = state_q;
    char_ready_d = 1'b0;
    we_d         = 1'b0;
    oe_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    col_d        = col_q;
    row_d        = row_q;
    idx_d        = idx_q;
    adv_row_c    = 1'b0;

    case (state_q)
      IDLE: begin
        char_ready_d = 1'b1;
        if (accept_c) begin
          // One cycle of char_ready low after every accept, even for
          // bytes that need no RAM access.
          char_ready_d = 1'b0;
          if (is_print_c) begin
            state_d = WRITE;
            addr_d  = cell_addr(row_q, col_q);
            data_d  = {attr, char_data};
            we_d    = go_c;
          end else begin
            case (char_data)
              CH_CR: col_d = '0;
              CH_LF: begin
                col_d     = '0;
                adv_row_c = 1'b1;
              end
              CH_BS: begin
                if (col_q != '0) col_d = col_q - COL_W'(1);
              end
              CH_FF: begin
                state_d = CLEAR;
                idx_d   = '0;
                addr_d  = '0;
                data_d  = {clr_attr, CH_SPACE};
                we_d    = go_c;
              end
              default: ;
            endcase
          end
        end
      end

      WRITE: begin
        if (we_q) begin
          state_d      = IDLE;
          char_ready_d = 1'b1;
          if (col_q != LAST_COL) begin
            col_d = col_q + COL_W'(1);
          end else begin
            col_d     = '0;
            adv_row_c = 1'b1;
          end
        end else begin
          we_d = go_c;
        end
      end

      SCR_RD: begin
        // Once issued, a read always completes through SCR_WAIT.
        if (oe_q) state_d = SCR_WAIT;
        else      oe_d    = go_c;
      end

      SCR_WAIT: begin
        data_d  = cpu_dataIn;
        addr_d  = idx_q;
        state_d = SCR_WR;
        we_d    = go_c;
      end

      SCR_WR: begin
        if (we_q) begin
          if (idx_q == LAST_SCROLL) begin
            state_d = FILL;
            idx_d   = FILL_BASE;
            addr_d  = FILL_BASE;
            data_d  = {clr_attr, CH_SPACE};
            we_d    = go_c;
          end else begin
            state_d = SCR_RD;
            idx_d   = idx_q + AW'(1);
            addr_d  = AW'(32'(idx_q) + N_COL + 32'd1);
            oe_d    = go_c;
          end
        end else begin
          we_d = go_c;
        end
      end

      FILL, CLEAR: begin
        if (we_q) begin
          if (idx_q == LAST_CELL) begin
            state_d      = IDLE;
            char_ready_d = 1'b1;
            if (state_q == CLEAR) begin
              col_d = '0;
              row_d = '0;
            end
          end else begin
            idx_d  = idx_q + AW'(1);
            addr_d = idx_q + AW'(1);
            data_d = {clr_attr, CH_SPACE};
            we_d   = go_c;
          end
        end else begin
          we_d = go_c;
        end
      end

      default: state_d = IDLE;
    endcase

    // Row advance: move down, or scroll when already on the last row.
    if (adv_row_c) begin
      if (row_q != LAST_ROW) begin
        row_d = row_q + ROW_W'(1);
      end else begin
        state_d      = SCR_RD;
        char_ready_d = 1'b0;
        idx_d        = '0;
        addr_d       = ROW1_BASE;
        oe_d         = go_c;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State, output and cursor registers.
  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      char_ready_q <= 1'b0;
      we_q         <= 1'b0;
      oe_q         <= 1'b0;
      busy_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      char_ready_q <= char_ready_d;
      we_q         <= we_d;
      oe_q         <= oe_d;
      busy_q       <= busy_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      col_q        <= col_d;
      row_q        <= row_d;
      idx_q        <= idx_d;
    end
  end

  // Two-flop synchroniser bringing vBlank into the cpu_clk domain.
  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      vb_meta_q <= 1'b0;
      vb_sync_q <= 1'b0;
    end else begin
      vb_meta_q <= vBlank;
      vb_sync_q <= vb_meta_q;
    end
  end

  assign char_ready  = char_ready_q;
  assign cpu_we      = we_q;
  assign cpu_oe      = oe_q;
  assign busy        = busy_q;
  assign cpu_addr    = 16'(addr_q);
  assign cpu_dataOut = data_q;
  assign cursor_col  = col_q;
  assign cursor_row  = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: a 4x3 console with ungated RAM access
// checked against a terminal model, plus a vBlank-gated instance.
module tb_text_console_writer;

  localparam int unsigned NC    = 4;
  localparam int unsigned NR    = 3;
  localparam int unsigned CELLS = NC * NR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic mem_init;

  // Instance 0: SYNC_VBLANK = 0
  logic        valid0, ready0, we0, oe0, busy0;
  logic [7:0]  data0, attr0, clr0;
  logic [15:0] addr0, dout0, din0;
  logic [1:0]  col0, row0;

  // Instance 1: SYNC_VBLANK = 1
  logic        valid1, ready1, we1, oe1, busy1, vblank1;
  logic [7:0]  data1, attr1, clr1;
  logic [15:0] addr1, dout1;
  logic [1:0]  col1, row1;

  int n_chk = 0;
  int n_err = 0;
  int n_we1 = 0;

  text_console_writer #(.N_COL(NC), .N_ROW(NR), .SYNC_VBLANK(1'b0)) dut0 (
    .cpu_clk(clk), .rst_n(rst_n),
    .char_valid(valid0), .char_data(data0), .char_ready(ready0),
    .attr(attr0), .clr_attr(clr0), .vBlank(1'b0),
    .cpu_addr(addr0), .cpu_we(we0), .cpu_oe(oe0),
    .cpu_dataOut(dout0), .cpu_dataIn(din0),
    .cursor_col(col0), .cursor_row(row0), .busy(busy0)
  );

  text_console_writer #(.N_COL(NC), .N_ROW(NR), .SYNC_VBLANK(1'b1)) dut1 (
    .cpu_clk(clk), .rst_n(rst_n),
    .char_valid(valid1), .char_data(data1), .char_ready(ready1),
    .attr(attr1), .clr_attr(clr1), .vBlank(vblank1),
    .cpu_addr(addr1), .cpu_we(we1), .cpu_oe(oe1),
    .cpu_dataOut(dout1), .cpu_dataIn(16'h0000),
    .cursor_col(col1), .cursor_row(row1), .busy(busy1)
  );

  // Character generator text RAM seen by instance 0 (one-cycle read latency).
  logic [15:0] dev_mem [CELLS];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < int'(CELLS); k++) dev_mem[k] <= 16'hA000 + 16'(k);
    end else begin
      if (we0 && addr0 < 16'(CELLS)) dev_mem[int'(addr0)] <= dout0;
      if (oe0 && addr0 < 16'(CELLS)) din0 <= dev_mem[int'(addr0)];
    end
  end

  // Terminal model and scoreboard queues.
  logic [31:0] wq [$];
  logic [15:0] rq [$];
  logic [15:0] mram [CELLS];
  int mcol, mrow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input int a, input logic [15:0] d);
    wq.push_back({16'(a), d});
    mram[a] = d;
  endtask

  task automatic row_adv();
    if (mrow < int'(NR) - 1) begin
      mrow++;
    end else begin
      for (int i = 0; i < int'(NC * (NR - 1)); i++) begin
        rq.push_back(16'(i + int'(NC)));
        push_w(i, mram[i + int'(NC)]);
      end
      for (int j = 0; j < int'(NC); j++) push_w(int'(NC * (NR - 1)) + j, {clr0, 8'h20});
    end
  endtask

  task automatic model_apply(input logic [7:0] c, input logic [7:0] a);
    if (c >= 8'h20 && c != 8'h7F) begin
      push_w(mrow * int'(NC) + mcol, {a, c});
      if (mcol < int'(NC) - 1) mcol++;
      else begin
        mcol = 0;
        row_adv();
      end
    end else begin
      case (c)
        8'h0D: mcol = 0;
        8'h0A: begin mcol = 0; row_adv(); end
        8'h08: if (mcol > 0) mcol--;
        8'h0C: begin
          for (int k = 0; k < int'(CELLS); k++) push_w(k, {clr0, 8'h20});
          mcol = 0;
          mrow = 0;
        end
        default: ;
      endcase
    end
  endtask

  // Per-cycle monitor for instance 0: invariants and scoreboard pops.
  always @(negedge clk) begin
    if (rst_n && !mem_init) begin
      chk("we_oe_exclusive", 32'(we0 & oe0), 32'd0);
      chk("ready_while_busy", 32'(ready0 & busy0), 32'd0);
      if (we0) begin
        if (wq.size() == 0) chk("write_unexpected", 32'(wq.size()), 32'd1);
        else begin
          logic [31:0] e;
          e = wq.pop_front();
          chk("wr_addr", 32'(addr0), 32'(e[31:16]));
          chk("wr_data", 32'(dout0), 32'(e[15:0]));
        end
      end
      if (oe0) begin
        if (rq.size() == 0) chk("read_unexpected", 32'(rq.size()), 32'd1);
        else begin
          logic [15:0] ra;
          ra = rq.pop_front();
          chk("rd_addr", 32'(addr0), 32'(ra));
        end
      end
    end
  end

  // Write counter for instance 1.
  always @(negedge clk) if (rst_n && we1) n_we1++;

  // Send one byte to instance 0; keep leaves valid high for a following byte.
  task automatic send0(input logic [7:0] c, input logic [7:0] a, input bit keep);
    int b;
    model_apply(c, a);
    @(negedge clk);
    valid0 = 1'b1;
    data0  = c;
    attr0  = a;
    b = 0;
    while (!ready0 && b < 2000) begin
      @(negedge clk);
      b++;
    end
    if (!ready0) begin
      chk("accept_timeout", 32'(ready0), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $fatal(1, "FAIL accept_timeout: byte never accepted");
    end
    @(posedge clk);
    #1;
    valid0 = keep;
  endtask

  task automatic wait_idle0();
    int b;
    b = 0;
    @(negedge clk);
    while ((busy0 || !ready0) && b < 5000) begin
      @(negedge clk);
      b++;
    end
    chk("idle_timeout", 32'(busy0 || !ready0), 32'd0);
  endtask

  // Count busy cycles (and reads) following an accept.
  task automatic measure_busy(output int nb, output int nrd);
    nb = 0;
    nrd = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (!busy0) break;
      nb++;
      if (oe0) nrd++;
    end
  endtask

  initial begin
    int nb, nrd, d, base;
    logic [7:0] c, a;

    rst_n = 1'b0; mem_init = 1'b1;
    valid0 = 1'b0; data0 = 8'h00; attr0 = 8'h00; clr0 = 8'h07;
    valid1 = 1'b0; data1 = 8'h00; attr1 = 8'h00; clr1 = 8'h07; vblank1 = 1'b0;
    for (int k = 0; k < int'(CELLS); k++) mram[k] = 16'hA000 + 16'(k);
    mcol = 0; mrow = 0;

    // Reset state
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    chk("rst_ready", 32'(ready0), 32'd0);
    chk("rst_we_oe", 32'({we0, oe0}), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_addr", 32'(addr0), 32'd0);
    chk("rst_data", 32'(dout0), 32'd0);
    chk("rst_cursor", 32'({col0, row0}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(ready0), 32'd1);
    chk("ready1_after_rst", 32'(ready1), 32'd1);

    // Single printable: write cycle, then ready returns with cursor advanced
    send0(8'h41, 8'h1F, 1'b0);
    @(negedge clk);
    chk("A_we", 32'(we0), 32'd1);
    chk("A_addr", 32'(addr0), 32'd0);
    chk("A_data", 32'(dout0), 32'h1F41);
    chk("A_ready_low", 32'(ready0), 32'd0);
    @(negedge clk);
    chk("A_ready_back", 32'(ready0), 32'd1);
    chk("A_we_off", 32'(we0), 32'd0);
    chk("A_cursor", 32'({col0, row0}), 32'({2'd1, 2'd0}));

    // Row wrap, CR, backspace at column 0
    send0(8'h0D, 8'h1F, 1'b1);
    for (int i = 0; i < 4; i++) send0(8'h61 + 8'(i), 8'h12, 1'b1);
    send0(8'h0D, 8'h12, 1'b0);
    wait_idle0();
    chk("wrap_cursor", 32'({col0, row0}), 32'({2'd0, 2'd1}));
    send0(8'h42, 8'h13, 1'b0);
    wait_idle0();
    chk("B_cursor", 32'({col0, row0}), 32'({2'd1, 2'd1}));
    send0(8'h0D, 8'h13, 1'b1);
    send0(8'h08, 8'h13, 1'b0);
    wait_idle0();
    chk("bs_col0_cursor", 32'({col0, row0}), 32'({2'd0, 2'd1}));

    // Clear, then fill all cells (auto-wrap scroll on the last cell)
    send0(8'h0C, 8'h00, 1'b0);
    measure_busy(nb, nrd);
    chk("ff_busy_cycles", 32'(nb), 32'd12);
    wait_idle0();
    chk("ff_cursor", 32'({col0, row0}), 32'd0);
    for (int i = 0; i < 12; i++) send0(8'h30 + 8'(i), 8'h1E, i != 11);
    wait_idle0();
    chk("autoscroll_cursor", 32'({col0, row0}), 32'({2'd0, 2'd2}));

    // LF on the last row: 8 cells x 3 cycles + 4 fill cycles
    send0(8'h0A, 8'h00, 1'b0);
    measure_busy(nb, nrd);
    chk("lf_scroll_busy_cycles", 32'(nb), 32'd28);
    chk("lf_scroll_reads", 32'(nrd), 32'd8);
    wait_idle0();
    chk("lf_scroll_cursor", 32'({col0, row0}), 32'({2'd0, 2'd2}));

    send0(8'h0C, 8'h00, 1'b0);
    wait_idle0();
    chk("ff2_cursor", 32'({col0, row0}), 32'd0);

    // Reset in the middle of a scroll
    send0(8'h0A, 8'h00, 1'b1);
    send0(8'h0A, 8'h00, 1'b1);
    send0(8'h0A, 8'h00, 1'b0);
    repeat (10) @(negedge clk);
    chk("midscroll_busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_strobes", 32'({we0, oe0}), 32'd0);
    chk("mid_rst_busy_ready", 32'({busy0, ready0}), 32'd0);
    chk("mid_rst_cursor", 32'({col0, row0}), 32'd0);
    wq.delete();
    rq.delete();
    for (int k = 0; k < int'(CELLS); k++) mram[k] = dev_mem[k];
    mcol = 0;
    mrow = 0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_back", 32'(ready0), 32'd1);

    // Random stream with valid held high throughout
    for (int i = 0; i < 200; i++) begin
      d = int'($urandom_range(0, 99));
      if (d < 60)      c = 8'($urandom_range(32, 255));
      else if (d < 70) c = 8'h0D;
      else if (d < 82) c = 8'h0A;
      else if (d < 92) c = 8'h08;
      else if (d < 94) c = 8'h0C;
      else             c = 8'($urandom_range(0, 31));
      a = 8'($urandom);
      send0(c, a, i != 199);
    end
    wait_idle0();
    for (int k = 0; k < int'(CELLS); k++) chk("ram_image", 32'(dev_mem[k]), 32'(mram[k]));
    chk("rand_cursor", 32'({col0, row0}), 32'({2'(mcol), 2'(mrow)}));
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);

    // vBlank-gated instance: no write while vBlank is low
    @(negedge clk);
    valid1 = 1'b1; data1 = 8'h43; attr1 = 8'h2E;
    d = 0;
    while (!ready1 && d < 50) begin @(negedge clk); d++; end
    chk("vb_accept", 32'(ready1), 32'd1);
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    base = n_we1;
    repeat (20) @(negedge clk);
    chk("vb_hold_no_write", 32'(n_we1 - base), 32'd0);
    chk("vb_hold_busy", 32'(busy1), 32'd1);
    chk("vb_hold_ready", 32'(ready1), 32'd0);
    vblank1 = 1'b1;
    d = 0;
    while (!we1 && d < 10) begin @(negedge clk); d++; end
    chk("vb_write_seen", 32'(we1), 32'd1);
    chk("vb_latency_ok", 32'(d >= 2 && d <= 3), 32'd1);
    chk("vb_addr", 32'(addr1), 32'd0);
    chk("vb_data", 32'(dout1), 32'h2E43);
    repeat (5) @(negedge clk);
    chk("vb_single_write", 32'(n_we1 - base), 32'd1);
    chk("vb_idle", 32'({busy1, ready1}), 32'({1'b0, 1'b1}));
    chk("vb_cursor", 32'({col1, row1}), 32'({2'd1, 2'd0}));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
